uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter with a ready/valid input, a one-word holding buffer and configurable frame format. Data width, stop-bit count and optional parity are set per instance. It replaces the fixed 8N1 transmitter in the serial link path and sits between the packet/byte source and the TX pin. Buffered back-to-back frames are sent with no idle bits between them.

## Interface
- CLOCK_RATE, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, line rate in bit/s; CLK_PER_BIT = CLOCK_RATE/BAUD_RATE (integer truncation), must be ≥ 2
- DATA_WIDTH, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, number of stop bits, 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only used with UART_TX_PARITY_EN

- clk  input  1  system clock, rising edge
- arst_n  input  1  asynchronous reset, active-low
- s_valid  input  1  source offers s_data
- s_ready  output  1  holding buffer empty, registered
- s_data  input  DATA_WIDTH  word to transmit, LSB sent first
- active  output  1  frame on the line, start through last stop bit
- done  output  1  one-cycle pulse per completed frame
- q  output  1  serial line, registered, idles high

## Operation
- Reset (arst_n low, any state):
  - q=1, active=0, done=0, s_ready=0.
  - Holding buffer cleared; state IDLE; all counters 0.
  - A frame in flight is abandoned with no stop bit.
- s_ready goes to 1 on the first clk edge after reset release. After that, s_ready = not buffer-full.
- Handshake: on a rising edge where s_valid && s_ready:
  - s_data is captured into the buffer.
  - s_ready drops to 0 on that same edge.
  - s_data is don't-care at all other times.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - q=1, active=0.
  - If the buffer is full: load the shifter from the buffer, clear buffer-full, set s_ready=1, go to START.
- START: q=0 for CLK_PER_BIT cycles, then go to DATA.
- DATA:
  - q = shifter[bit_cnt], bit_cnt counting 0..DATA_WIDTH-1.
  - Each bit is held for CLK_PER_BIT cycles.
  - After the last bit, go to PARITY if enabled, otherwise STOP.
- PARITY: q = XOR of the loaded word, XOR PARITY_ODD. Held for CLK_PER_BIT cycles, then go to STOP.
- STOP:
  - q=1 for STOP_BITS×CLK_PER_BIT cycles.
  - At the final cycle, if the buffer is full: reload the shifter, clear the buffer and go straight to START (zero idle bits, active stays 1).
  - Otherwise go to IDLE.
- The buffer accepts the next word at any time during a frame.
- Frame length = 1 + DATA_WIDTH + P + STOP_BITS bits, where P = 1 with parity and 0 without.
- Counters:
  - clk_cnt is $clog2(CLK_PER_BIT) bits wide and wraps to 0 at CLK_PER_BIT-1.
  - bit_cnt is $clog2(DATA_WIDTH+1) bits wide.
  - A stop-bit counter is 1 bit wide.
- Illegal state encoding returns to IDLE with q=1.

## Timing
- Handshake edge H → buffer full after H.
- From IDLE: q falls on edge H+1, and active rises on H+1.
- Every line bit lasts exactly CLK_PER_BIT clk cycles.
- done:
  - Goes high on the edge that ends the last stop bit, for exactly one cycle.
  - It coincides with the first START cycle of a chained frame, or the first IDLE cycle.
- Back-to-back: the falling edge of the second start bit is exactly frame_length×CLK_PER_BIT cycles after the first start bit. active does not deassert between the frames.
- Handshake and reload on the same edge cannot happen, because s_ready=0 while the buffer is full.
- Reset release: the first legal handshake is on the second edge after release.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state and parity bit are compiled in, and PARITY_ODD selects the sense.
  - Undefined: the PARITY state and parity logic are absent, frames carry no parity bit, and PARITY_ODD is ignored.

## Test plan
All tests use CLOCK_RATE=1_000_000 and BAUD_RATE=100_000 (CLK_PER_BIT=10).
- Reset:
  - Stimulus: hold arst_n=0 for 5 cycles, then release.
  - During reset: q=1, active=0, done=0, s_ready=0.
  - After release: s_ready=1 after the first edge; q stays 1 with no stimulus.
- 8N1, 0xA5:
  - Stimulus: send 0xA5 with parity disabled.
  - q sequence, each level held 10 cycles: 0,1,0,1,0,0,1,0,1,1.
  - q falls 1 cycle after the handshake; done pulses once, 100 cycles after q falls.
- Parity:
  - Stimulus: send 0x07 with UART_TX_PARITY_EN defined.
  - PARITY_ODD=0 → parity bit 1; PARITY_ODD=1 → parity bit 0.
  - Frame is 110 cycles.
- Back-to-back:
  - Stimulus: send 0x55, then offer 0x0F 20 cycles later.
  - 0x0F is accepted immediately, and s_ready stays 0 until the reload.
  - The second start bit begins on the cycle after the first stop bit ends.
  - active stays high for 200 cycles; done pulses at 100 and 200.
- Format DATA_WIDTH=7, STOP_BITS=2:
  - Stimulus: send 0x41.
  - Frame is 100 cycles: start, 7 data bits LSB first, and 20 cycles of stop high.
- Reset mid-frame:
  - Stimulus: assert arst_n during data bit 3, with a second word buffered.
  - q=1 immediately; the buffered word is dropped; no done pulse.
  - After release: no frame is sent until a new handshake.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: ready/valid input, one-word holding buffer, configurable frame.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  active,
  output logic                  done,
  output logic                  q
);

  localparam int CLK_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (CLK_PER_BIT < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;
  localparam logic POL = (PARITY_ODD != 0);
  logic par;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  state_t                state;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shifter;
  logic [DATA_WIDTH-1:0] hold;
  logic                  full;

  logic take, bit_end, stop_end, reload, full_nxt;

  // A reload and a handshake never share an edge: s_ready is low while full.
  always_comb begin
    take     = s_valid && s_ready;
    bit_end  = (clk_cnt == CNT_LAST);
    stop_end = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
    reload   = full && ((state == IDLE) || stop_end);
    full_nxt = full;
    if (take)        full_nxt = 1'b1;
    else if (reload) full_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shifter  <= '0;
      hold     <= '0;
      full     <= 1'b0;
      s_ready  <= 1'b0;
      active   <= 1'b0;
      done     <= 1'b0;
      q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      full    <= full_nxt;
      s_ready <= !full_nxt;
      if (take) hold <= s_data;
      if (reload) begin
        shifter <= hold;
`ifdef UART_TX_PARITY_EN
        par     <= (^hold) ^ POL;
`endif
      end
      case (state)
        IDLE: begin
          q        <= 1'b1;
          active   <= 1'b0;
          clk_cnt  <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          if (full) begin
            state  <= START;
            q      <= 1'b0;
            active <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= DATA;
            q       <= shifter[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              q       <= par;
`else
              state   <= STOP;
              q       <= 1'b1;
`endif
            end else begin
              // LSB-first: shift down so the next bit is always at [0].
              bit_cnt <= bit_cnt + 1'b1;
              shifter <= shifter >> 1;
              q       <= shifter[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= STOP;
            q       <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              stop_cnt <= 1'b0;
              done     <= 1'b1;
              if (full) begin
                state <= START;
                q     <= 1'b0;
              end else begin
                state  <= IDLE;
                q      <= 1'b1;
                active <= 1'b0;
              end
            end else begin
              stop_cnt <= ~stop_cnt;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          q        <= 1'b1;
          active   <= 1'b0;
          clk_cnt  <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
        end
      endcase
    end
  end

endmodule
